// File: rtl/zrb_uart_frame_rx.sv
// zrb_uart_frame_rx: deframer downstream of zrb_uart_rx.
// It hunts for SYNC, takes LEN and then LEN payload bytes into a buffer,
// and checks an 8-bit additive checksum. Only good frames are released on
// the m_* valid/ready stream.
// Ports:
//   clk, reset (async, active-low)
//   rx_data/rx_valid        byte strobes from the UART receiver
//   m_data/m_valid/m_ready  payload stream; m_last marks the final byte
//   frame_ok/frame_err      one-cycle result pulses; err_code holds the last error
//   overrun                 one-cycle pulse when a byte is dropped during DRAIN
//   busy                    high whenever the block is not hunting for SYNC
module zrb_uart_frame_rx #(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       sum_q, sum_d;
  logic [IDX_W-1:0] lenm1_q, lenm1_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             ovr_q, ovr_d;
  logic             we_c;
  logic [7:0]       sum_next_c;
  logic [7:0]       buf_q [MAX_LEN];

  assign sum_next_c = sum_q + rx_data;

  // Next-state and control
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    lenm1_d  = lenm1_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    ovr_d    = 1'b0;
    we_c     = 1'b0;

    unique case (state_q)
      S_HUNT: begin
        if (rx_valid && (rx_data == SYNC)) begin
          state_d = S_LEN;
          cnt_d   = '0;
        end
      end

      S_LEN, S_DATA, S_CHK: begin
        cnt_d = cnt_q + TO_W'(1);
        if (rx_valid) begin
          // An arriving byte always beats a same-cycle timeout.
          cnt_d = '0;
          if (state_q == S_LEN) begin
            sum_d = rx_data;
            if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
              err_d   = 1'b1;
              code_d  = ERR_LEN;
              state_d = S_HUNT;
            end else begin
              lenm1_d  = IDX_W'(rx_data - 8'd1);
              wr_idx_d = '0;
              state_d  = S_DATA;
            end
          end else if (state_q == S_DATA) begin
            we_c     = 1'b1;
            sum_d    = sum_next_c;
            wr_idx_d = wr_idx_q + IDX_W'(1);
            if (wr_idx_q == lenm1_q) state_d = S_CHK;
          end else begin
            if (sum_next_c == 8'd0) begin
              ok_d     = 1'b1;
              rd_idx_d = '0;
              state_d  = S_DRAIN;
            end else begin
              err_d   = 1'b1;
              code_d  = ERR_CHK;
              state_d = S_HUNT;
            end
          end
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          // Counter reaches TIMEOUT on this idle cycle.
          err_d   = 1'b1;
          code_d  = ERR_TO;
          state_d = S_HUNT;
        end
      end

      S_DRAIN: begin
        if (rx_valid) ovr_d = 1'b1;
        if (m_ready) begin
          if (rd_idx_q == lenm1_q) state_d = S_HUNT;
          else                     rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end

      default: state_d = S_HUNT;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_HUNT;
      sum_q    <= '0;
      lenm1_q  <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      lenm1_q  <= lenm1_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      ovr_q    <= ovr_d;
    end
  end

  // Payload buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (we_c) buf_q[wr_idx_q] <= rx_data;
  end

  // Stream outputs decode from registered state so they read 0 outside DRAIN
  assign m_valid   = (state_q == S_DRAIN);
  assign m_data    = m_valid ? buf_q[rd_idx_q] : 8'h00;
  assign m_last    = m_valid && (rd_idx_q == lenm1_q);
  assign busy      = (state_q != S_HUNT);
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_zrb_uart_frame_rx.sv
// Directed bench for zrb_uart_frame_rx (TIMEOUT shortened to 100).
module tb_zrb_uart_frame_rx;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  int n_cmp;
  int n_err;

  zrb_uart_frame_rx #(
    .MAX_LEN (16),
    .SYNC    (8'hA5),
    .TIMEOUT (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Good frame A5 03 11 22 33 97 up to the checksum strobe.
  task automatic send_good();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
  endtask

  // Payload 11 22 33 delivered with m_ready high, first byte already presented.
  task automatic expect_stream(input string tag);
    chk_eq({tag, "_d0"}, {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'h11});
    tick();
    chk_eq({tag, "_ok_1cyc"}, frame_ok, 1'b0);
    chk_eq({tag, "_d1"}, {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'h22});
    tick();
    chk_eq({tag, "_d2"}, {m_valid, m_last, m_data}, {1'b1, 1'b1, 8'h33});
    tick();
    chk_eq({tag, "_idle"}, {busy, m_valid, m_last}, 3'b000);
  endtask

  initial begin
    int early;
    int ovr_cnt;
    int hold_bad;
    int vld_seen;
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    m_ready  = 1'b1;

    // Reset state
    tick(); tick();
    chk_eq("rst_outs", {m_data, m_valid, m_last, frame_ok, frame_err, err_code, overrun, busy},
           16'h0000);
    reset = 1'b1;
    tick();

    // Good frame with m_ready high
    send_good();
    chk_eq("good_ok", {frame_ok, frame_err, busy}, 3'b101);
    expect_stream("good");
    chk_eq("good_code", err_code, 2'b00);

    // Bad checksum
    vld_seen = 0;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    if (m_valid) vld_seen++;
    send(8'h98);
    chk_eq("badchk_err", {frame_err, frame_ok, err_code}, 4'b1010);
    if (m_valid) vld_seen++;
    tick();
    if (m_valid) vld_seen++;
    chk_eq("badchk_pulse", {frame_err, busy}, 2'b00);
    chk_eq("badchk_novalid", vld_seen, 0);

    // Bad lengths, then a good frame
    send(8'hA5); send(8'h00);
    chk_eq("len0_err", {frame_err, err_code, busy}, 4'b1010);
    tick();
    send(8'hA5); send(8'h11);
    chk_eq("len17_err", {frame_err, err_code, busy}, 4'b1010);
    send_good();
    chk_eq("after_len_ok", frame_ok, 1'b1);
    expect_stream("after_len");
    chk_eq("after_len_code", err_code, 2'b01);

    // Timeout: frame_err exactly 100 edges after the last byte
    send(8'hA5); send(8'h02); send(8'h11);
    early = 0;
    for (int i = 1; i < 100; i++) begin
      tick();
      if (frame_err) early++;
    end
    chk_eq("to_early", early, 0);
    chk_eq("to_busy_before", busy, 1'b1);
    tick();
    chk_eq("to_fire", {frame_err, err_code, busy}, 4'b1110);
    tick();
    chk_eq("to_pulse", frame_err, 1'b0);

    // Backpressure with bytes injected during DRAIN
    m_ready = 1'b0;
    send_good();
    chk_eq("bp_ok", {frame_ok, m_valid, m_data}, {2'b11, 8'h11});
    ovr_cnt  = 0;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3)      begin rx_valid = 1'b1; rx_data = 8'h55; end
      else if (i == 8) begin rx_valid = 1'b1; rx_data = 8'h66; end
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      if (overrun) ovr_cnt++;
      if (!m_valid || m_data != 8'h11 || m_last || frame_ok) hold_bad++;
    end
    chk_eq("bp_hold", hold_bad, 0);
    chk_eq("bp_overrun", ovr_cnt, 2);
    m_ready = 1'b1;
    expect_stream("bp");

    // Reset mid-DATA, then good frame
    send(8'hA5); send(8'h04); send(8'h11); send(8'h22);
    #2 reset = 1'b0;
    #1;
    chk_eq("rst_mid_outs", {m_data, m_valid, m_last, frame_ok, frame_err, err_code, overrun, busy},
           16'h0000);
    tick();
    chk_eq("rst_mid_hold", {m_valid, busy, err_code}, 4'b0000);
    reset = 1'b1;
    tick();
    send(8'h33);
    chk_eq("rst_no_out", {m_valid, frame_ok, frame_err, busy}, 4'b0000);
    send_good();
    chk_eq("rst_good_ok", {frame_ok, err_code}, 3'b100);
    expect_stream("rst_good");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
